// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the four-master round-robin bus arbiter.
// Holds the active-low enable levels, the owner and hold-counter types,
// and the helper that turns an owner index into the active-low grant vector.
package bus_arbiter_pkg;

  // Active-low handshake levels used on every req_/grnt_ line.
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef logic [1:0] bus_owner_t;

  localparam bus_owner_t BUS_OWNER_MASTER_0 = 2'd0;
  localparam bus_owner_t BUS_OWNER_MASTER_1 = 2'd1;
  localparam bus_owner_t BUS_OWNER_MASTER_2 = 2'd2;
  localparam bus_owner_t BUS_OWNER_MASTER_3 = 2'd3;

  typedef logic [15:0] bus_hold_cnt_t;

  localparam bus_hold_cnt_t BUS_HOLD_CNT_MAX = 16'hFFFF;

  // One-cold grant vector: only the owner's bit is driven to ENABLE_.
  function automatic logic [3:0] grant_decode(input bus_owner_t owner);
    logic [3:0] grnt;
    grnt        = {4{DISABLE_}};
    grnt[owner] = ENABLE_;
    return grnt;
  endfunction

endpackage

// File: rtl/bus_arb_rr_pick.sv
// Combinational round-robin pick.
// Scans owner+1, owner+2, owner+3 (mod 4) and returns the first master whose
// active-low request is asserted. The current owner itself is never picked.
// Ports:
//   owner_i  current owner index
//   req_n_i  active-low requests, bit i = master i
//   pick_o   next owner candidate (equals owner_i when nothing is found)
//   found_o  high when some other master is requesting
module bus_arb_rr_pick
  import bus_arbiter_pkg::*;
(
  input  bus_owner_t owner_i,
  input  logic [3:0] req_n_i,
  output bus_owner_t pick_o,
  output logic       found_o
);

  bus_owner_t cand1_s;
  bus_owner_t cand2_s;
  bus_owner_t cand3_s;

  // Two-bit addition wraps naturally, so owner 3 scans 0, 1, 2.
  assign cand1_s = owner_i + 2'd1;
  assign cand2_s = owner_i + 2'd2;
  assign cand3_s = owner_i + 2'd3;

  // Priority scan in rotation order starting just after the owner.
  always_comb begin
    pick_o  = owner_i;
    found_o = 1'b0;
    if (req_n_i[cand1_s] == ENABLE_) begin
      pick_o  = cand1_s;
      found_o = 1'b1;
    end else if (req_n_i[cand2_s] == ENABLE_) begin
      pick_o  = cand2_s;
      found_o = 1'b1;
    end else if (req_n_i[cand3_s] == ENABLE_) begin
      pick_o  = cand3_s;
      found_o = 1'b1;
    end else begin
      pick_o  = owner_i;
      found_o = 1'b0;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the four masters of the shared system bus.
// The bus is always parked on one owner; ownership rotates when the owner
// releases, and an optional hold limit preempts an owner that keeps the bus
// while others wait.
// Ports:
//   clk                 system clock, rising edge
//   reset               synchronous active-high reset
//   m0_req_..m3_req_    active-low bus requests
//   m0_grnt_..m3_grnt_  active-low grants, exactly one asserted
//   owner               current owner index
//   preempt             one-cycle pulse in the first cycle after a forced handoff
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_LIMIT = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  output logic [1:0] owner,
  output logic       preempt
);

  // A zero limit disables preemption; otherwise the owner is cut off once the
  // counter reaches LIMIT-1, i.e. after exactly LIMIT held cycles.
  localparam logic          PREEMPT_EN  = (HOLD_LIMIT != 0);
  localparam bus_hold_cnt_t HOLD_THRESH = (HOLD_LIMIT == 0) ? 16'd0 : 16'(HOLD_LIMIT - 1);

  bus_owner_t    owner_q,    owner_d;
  bus_hold_cnt_t hold_cnt_q, hold_cnt_d;
  logic          preempt_q,  preempt_d;

  logic [3:0] req_n_s;
  logic       owner_req_s;
  bus_owner_t pick_s;
  logic       found_s;
  logic       preempt_hit_s;

  assign req_n_s     = {m3_req_, m2_req_, m1_req_, m0_req_};
  assign owner_req_s = (req_n_s[owner_q] == ENABLE_);

  // One picker serves both the release and the preempt handoff.
  bus_arb_rr_pick u_pick (
    .owner_i (owner_q),
    .req_n_i (req_n_s),
    .pick_o  (pick_s),
    .found_o (found_s)
  );

  assign preempt_hit_s = PREEMPT_EN && owner_req_s && found_s && (hold_cnt_q >= HOLD_THRESH);

  // Next-state: release handoff, preemption, or hold with saturating count.
  always_comb begin
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    preempt_d  = 1'b0;
    if (!owner_req_s) begin
      hold_cnt_d = 16'd0;
      if (found_s) begin
        owner_d = pick_s;
      end else begin
        owner_d = owner_q;
      end
    end else if (preempt_hit_s) begin
      owner_d    = pick_s;
      hold_cnt_d = 16'd0;
      preempt_d  = 1'b1;
    end else if (hold_cnt_q != BUS_HOLD_CNT_MAX) begin
      hold_cnt_d = hold_cnt_q + 16'd1;
    end else begin
      hold_cnt_d = hold_cnt_q;
    end
  end

  // State registers; reset overrides any arbitration on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q    <= BUS_OWNER_MASTER_0;
      hold_cnt_q <= 16'd0;
      preempt_q  <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
      preempt_q  <= preempt_d;
    end
  end

  // Grants come straight from the owner register, so they only change at clk.
  assign {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_} = grant_decode(owner_q);
  assign owner   = owner_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter. Three instances with hold limits
// 4, 0 and 1 share the clock, reset and request lines; each is tracked by a
// behavioural model that applies the arbitration rules with plain integers.
module tb_bus_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req_n;

  logic [3:0] grnt_n [3];
  logic [1:0] own    [3];
  logic       pre    [3];

  int checks   = 0;
  int failures = 0;

  int lim      [3] = '{4, 0, 1};
  int m_owner  [3];
  int m_held   [3];
  bit m_pre    [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    bus_arbiter #(.HOLD_LIMIT((g == 0) ? 4 : ((g == 1) ? 0 : 1))) u_dut (
      .clk      (clk),
      .reset    (reset),
      .m0_req_  (req_n[0]),
      .m1_req_  (req_n[1]),
      .m2_req_  (req_n[2]),
      .m3_req_  (req_n[3]),
      .m0_grnt_ (grnt_n[g][0]),
      .m1_grnt_ (grnt_n[g][1]),
      .m2_grnt_ (grnt_n[g][2]),
      .m3_grnt_ (grnt_n[g][3]),
      .owner    (own[g]),
      .preempt  (pre[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: one clock edge of every arbiter, from the rules in words.
  task automatic model_update(input logic rst, input logic [3:0] rq);
    for (int d = 0; d < 3; d++) begin
      int  pick;
      bit  found;
      bit  own_wants;
      found = 0;
      pick  = m_owner[d];
      for (int k = 1; k <= 3; k++) begin
        int idx;
        idx = (m_owner[d] + k) % 4;
        if (!found && rq[idx] == 1'b0) begin
          found = 1;
          pick  = idx;
        end
      end
      own_wants = (rq[m_owner[d]] == 1'b0);
      m_pre[d]  = 0;
      if (rst) begin
        m_owner[d] = 0;
        m_held[d]  = 0;
      end else if (!own_wants) begin
        m_held[d] = 0;
        if (found) m_owner[d] = pick;
      end else if (lim[d] != 0 && found && (m_held[d] + 1) >= lim[d]) begin
        // This cycle completes the owner's lim-th held cycle.
        m_owner[d] = pick;
        m_held[d]  = 0;
        m_pre[d]   = 1;
      end else begin
        m_held[d] = (m_held[d] < 65535) ? m_held[d] + 1 : 65535;
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("d%0d_owner", d), 32'(own[d]), 32'(m_owner[d]));
      check_eq($sformatf("d%0d_grnt", d), 32'(grnt_n[d]), 32'(4'hF & ~(4'b0001 << m_owner[d])));
      check_eq($sformatf("d%0d_preempt", d), 32'(pre[d]), 32'(m_pre[d]));
    end
  endtask

  task automatic step(input logic rst, input logic [3:0] rq);
    reset = rst;
    req_n = rq;
    @(posedge clk);
    model_update(rst, rq);
    #1;
    check_all();
  endtask

  initial begin
    logic [3:0] rq;
    int         hold_len;
    logic       rst_r;

    reset = 1'b1;
    req_n = 4'b0000;
    for (int d = 0; d < 3; d++) begin
      m_owner[d] = 0;
      m_held[d]  = 0;
      m_pre[d]   = 0;
    end

    // Reset with everyone requesting, then one cycle out of reset.
    repeat (3) step(1'b1, 4'b0000);
    check_eq("rst_owner", 32'(own[0]), 32'd0);
    check_eq("rst_grnt", 32'(grnt_n[0]), 32'h0000000E);
    check_eq("rst_preempt", 32'(pre[0]), 32'd0);
    step(1'b0, 4'b1100);
    check_eq("post_rst_owner", 32'(own[0]), 32'd0);
    check_eq("post_rst_preempt", 32'(pre[0]), 32'd0);

    // Limit 4: m0 holds exactly 4 cycles against m1, then forced handoff.
    step(1'b0, 4'b1100);
    check_eq("l4_hold2", 32'(own[0]), 32'd0);
    step(1'b0, 4'b1100);
    check_eq("l4_hold3", 32'(own[0]), 32'd0);
    step(1'b0, 4'b1100);
    check_eq("l4_pre_owner", 32'(own[0]), 32'd1);
    check_eq("l4_pre_pulse", 32'(pre[0]), 32'd1);
    step(1'b0, 4'b1100);
    check_eq("l4_pre_clear", 32'(pre[0]), 32'd0);
    check_eq("l4_m1_keeps", 32'(own[0]), 32'd1);
    step(1'b0, 4'b1110);
    check_eq("l4_back_to_m0", 32'(own[0]), 32'd0);
    check_eq("l4_release_nopre", 32'(pre[0]), 32'd0);

    // Rotation with wrap on the no-preempt instance.
    step(1'b0, 4'b0111);
    check_eq("rot_to_3", 32'(own[1]), 32'd3);
    step(1'b0, 4'b1010);
    check_eq("wrap_to_0", 32'(own[1]), 32'd0);
    step(1'b0, 4'b1011);
    check_eq("rot_to_2", 32'(own[1]), 32'd2);

    // Parking on master 1 with no requests.
    step(1'b0, 4'b1101);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'b1111);
      check_eq("park_owner", 32'(own[1]), 32'd1);
      check_eq("park_grnt", 32'(grnt_n[1]), 32'h0000000D);
    end

    // Limit 0: m2 keeps the bus for 1000 cycles while m3 waits.
    step(1'b0, 4'b1011);
    check_eq("l0_owner2", 32'(own[1]), 32'd2);
    for (int i = 0; i < 1000; i++) begin
      step(1'b0, 4'b0011);
    end
    check_eq("l0_still2", 32'(own[1]), 32'd2);

    // Reset in the middle of a transfer by master 3.
    step(1'b0, 4'b0111);
    check_eq("mid_owner3", 32'(own[1]), 32'd3);
    step(1'b0, 4'b0111);
    step(1'b1, 4'b0111);
    check_eq("mid_rst_owner", 32'(own[1]), 32'd0);
    step(1'b0, 4'b1001);
    check_eq("mid_next_m1", 32'(own[1]), 32'd1);

    // Random phase: bursts of biased requests with rare resets.
    for (int i = 0; i < 2000; i += hold_len) begin
      for (int b = 0; b < 4; b++) rq[b] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0) begin
        for (int b = 0; b < 4; b++) rq[b] = ($urandom_range(0, 3) == 0);
      end
      hold_len = $urandom_range(1, 8);
      for (int c = 0; c < hold_len; c++) begin
        rst_r = ($urandom_range(0, 199) == 0);
        step(rst_r, rq);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
